// File: rtl/sync_fifo_flags_pkg.sv
// fifo_pkg: shared types and helpers for sync_fifo_flags.
//   fifo_err_t      - sticky error flag pair {overflow, underflow}
//   fifo_ptr_next() - pointer increment that wraps at an arbitrary depth
//   fifo_cnt_width()- width needed to hold an occupancy of 0..depth
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Explicit wrap at depth-1 so non-power-of-two depths work.
    function automatic int unsigned fifo_ptr_next(input int unsigned ptr,
                                                  input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic int unsigned fifo_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned FIFO_DEFAULT_DEPTH = 4;
    localparam int unsigned FIFO_DEFAULT_CW    = $clog2(FIFO_DEFAULT_DEPTH + 1);

endpackage

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: bundle of the FIFO control, data and status signals.
//   master modport: the user side (drives flush/write/read/clear requests)
//   slave modport : the FIFO itself (drives read data, flags, count, errors)
// Parameters must match the ones given to sync_fifo_flags.
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = fifo_cnt_width(FIFO_DEPTH);

    logic                  flush_i;
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  rd_en_i;
    logic                  clr_err_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  empty_o;
    logic                  full_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic [CW-1:0]         fifo_count_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output flush_i, wr_en_i, wr_data_i, rd_en_i, clr_err_i,
        input  rd_data_o, rd_valid_o, empty_o, full_o, almost_full_o,
               almost_empty_o, fifo_count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, wr_en_i, wr_data_i, rd_en_i, clr_err_i,
        output rd_data_o, rd_valid_o, empty_o, full_o, almost_full_o,
               almost_empty_o, fifo_count_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/sync_fifo_flags_ptr_wrap.sv
// fifo_ptr_wrap: address pointer for a FIFO of DEPTH entries.
//   clk   - clock
//   rst_n - asynchronous active-low reset (pointer -> 0)
//   clr   - synchronous clear (pointer -> 0), wins over inc
//   inc   - advance by one, wrapping DEPTH-1 -> 0
//   ptr   - current pointer, $clog2(DEPTH) bits
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr;
        if (clr) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = AW'(fifo_ptr_next(32'(ptr), DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: synchronous FIFO with occupancy count, almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and flush.
// Any FIFO_DEPTH >= 2 is supported, including non-power-of-two.
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - sync_fifo_flags_if.slave: flush/write/read/clear requests in;
//           read data, rd_valid, empty/full/almost flags, count, errors out
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (rd_data_o shows the head word combinationally, rd_en_i pops it).
// Without it, rd_data_o is registered and rd_valid_o pulses after a read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_flags_if.slave  bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = fifo_cnt_width(FIFO_DEPTH);

    // Parameter sanity, caught at elaboration.
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flags: FIFO_DEPTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
        $error("sync_fifo_flags: AFULL_THRESH out of range 1..FIFO_DEPTH");
    end
    if (AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_flags: AEMPTY_THRESH out of range 0..FIFO_DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    fifo_err_t             err_reg;
    fifo_err_t             err_next;

    logic empty;
    logic full;
    logic rd_ok;
    logic wr_ok;
    logic rd_acc;
    logic wr_acc;
    logic ovf_set;
    logic unf_set;

    // Status flags are pure compares on the registered count.
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(FIFO_DEPTH));

    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.almost_full_o  = (count_reg >= CW'(AFULL_THRESH));
    assign bus.almost_empty_o = (count_reg <= CW'(AEMPTY_THRESH));
    assign bus.fifo_count_o   = count_reg;
    assign bus.overflow_o     = err_reg.overflow;
    assign bus.underflow_o    = err_reg.underflow;

    // A write into a full FIFO is fine when a read frees a slot this cycle.
    assign rd_ok = bus.rd_en_i && !empty;
    assign wr_ok = bus.wr_en_i && (!full || rd_ok);

    // Flush suppresses every accept and every error update in its cycle.
    assign rd_acc  = rd_ok && !bus.flush_i;
    assign wr_acc  = wr_ok && !bus.flush_i;
    assign ovf_set = bus.wr_en_i && !wr_ok && !bus.flush_i;
    assign unf_set = bus.rd_en_i && !rd_ok && !bus.flush_i;

    fifo_ptr_wrap #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush_i),
        .inc   (wr_acc),
        .ptr   (wr_addr)
    );

    fifo_ptr_wrap #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush_i),
        .inc   (rd_acc),
        .ptr   (rd_addr)
    );

    always_comb begin
        count_next = count_reg;
        if (bus.flush_i) begin
            count_next = '0;
        end else if (wr_acc && !rd_acc) begin
            count_next = count_reg + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Set has priority over clear so an error in the clearing cycle is kept.
    always_comb begin
        err_next.overflow  = ovf_set || (err_reg.overflow  && !bus.clr_err_i);
        err_next.underflow = unf_set || (err_reg.underflow && !bus.clr_err_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            err_reg   <= '0;
        end else begin
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    // Storage has no reset; stale contents are never exposed as valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= bus.wr_data_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through; zero while empty so the bus is quiet.
    assign bus.rd_data_o  = empty ? '0 : mem[rd_addr];
    assign bus.rd_valid_o = !empty;
`else
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_acc;
            if (rd_acc) begin
                rd_data_reg <= mem[rd_addr];
            end
        end
    end

    assign bus.rd_data_o  = rd_data_reg;
    assign bus.rd_valid_o = rd_valid_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed self-checking bench for sync_fifo_flags with
// DATA_WIDTH=8, FIFO_DEPTH=5, AFULL_THRESH=4, AEMPTY_THRESH=1.
// Read checks follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_sync_fifo_flags;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sync_fifo_flags_if #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) bus ();

    sync_fifo_flags #(
        .DATA_WIDTH    (8),
        .FIFO_DEPTH    (5),
        .AFULL_THRESH  (4),
        .AEMPTY_THRESH (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then land 1 time unit after the edge.
    task automatic step(input logic wr, input logic [7:0] wd, input logic rd,
                        input logic fl, input logic ce);
        bus.wr_en_i   = wr;
        bus.wr_data_i = wd;
        bus.rd_en_i   = rd;
        bus.flush_i   = fl;
        bus.clr_err_i = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.fifo_count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 ||
            bus.almost_empty_o !== 1'b1 || bus.almost_full_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: cnt=%0d e=%b f=%b ae=%b af=%b, want 0 1 0 1 0",
                     bus.fifo_count_o, bus.empty_o, bus.full_o, bus.almost_empty_o, bus.almost_full_o);
        end
        checks++;
        if (bus.rd_data_o !== 8'h00 || bus.rd_valid_o !== 1'b0 ||
            bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h v=%b ovf=%b unf=%b, want 00 0 0 0",
                     bus.rd_data_o, bus.rd_valid_o, bus.overflow_o, bus.underflow_o);
        end
        $display("reset: cnt=%0d empty=%b", bus.fifo_count_o, bus.empty_o);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(8'h11 * i), 1'b0, 1'b0, 1'b0);
            $display("write %h: cnt=%0d", 8'(8'h11 * i), bus.fifo_count_o);
            checks++;
            if (bus.fifo_count_o !== 3'(i) || bus.almost_empty_o !== (i <= 1) ||
                bus.almost_full_o !== (i >= 4) || bus.full_o !== (i == 5) || bus.empty_o !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: cnt=%0d ae=%b af=%b f=%b e=%b, want cnt=%0d ae=%b af=%b f=%b e=0",
                         i, bus.fifo_count_o, bus.almost_empty_o, bus.almost_full_o, bus.full_o,
                         bus.empty_o, i, (i <= 1), (i >= 4), (i == 5));
            end
`ifdef SYNC_FIFO_FWFT_EN
            checks++;
            if (bus.rd_data_o !== 8'h11 || bus.rd_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL fwft_head_%0d: data=%h v=%b, want 11 1", i, bus.rd_data_o, bus.rd_valid_o);
            end
`endif
        end
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        $display("write 66 to full: cnt=%0d ovf=%b", bus.fifo_count_o, bus.overflow_o);
        checks++;
        if (bus.overflow_o !== 1'b1 || bus.fifo_count_o !== 3'd5) begin
            errors++;
            $display("FAIL overflow: ovf=%b cnt=%0d, want 1 5", bus.overflow_o, bus.fifo_count_o);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr: ovf=%b, want 0", bus.overflow_o);
        end
    endtask

    task automatic test_read();
        for (int i = 0; i < 7; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            checks++;
            if (bus.rd_valid_o !== (i < 5) || bus.rd_data_o !== ((i < 5) ? 8'(8'h11 * (i + 1)) : 8'h00)) begin
                errors++;
                $display("FAIL read_%0d: data=%h v=%b, want %h %b", i, bus.rd_data_o, bus.rd_valid_o,
                         ((i < 5) ? 8'(8'h11 * (i + 1)) : 8'h00), (i < 5));
            end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`else
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.rd_valid_o !== (i < 5) || bus.rd_data_o !== ((i < 5) ? 8'(8'h11 * (i + 1)) : 8'h55)) begin
                errors++;
                $display("FAIL read_%0d: data=%h v=%b, want %h %b", i, bus.rd_data_o, bus.rd_valid_o,
                         ((i < 5) ? 8'(8'h11 * (i + 1)) : 8'h55), (i < 5));
            end
`endif
            $display("read %0d: data=%h valid=%b cnt=%0d unf=%b", i, bus.rd_data_o, bus.rd_valid_o,
                     bus.fifo_count_o, bus.underflow_o);
        end
        checks++;
        if (bus.underflow_o !== 1'b1 || bus.empty_o !== 1'b1 || bus.fifo_count_o !== 3'd0) begin
            errors++;
            $display("FAIL underflow: unf=%b e=%b cnt=%0d, want 1 1 0", bus.underflow_o, bus.empty_o, bus.fifo_count_o);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.rd_valid_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: v=%b unf=%b, want 0 0", bus.rd_valid_o, bus.underflow_o);
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h80 + r * 3 + k), 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
                checks++;
                if (bus.rd_data_o !== 8'(8'h80 + r * 3 + k)) begin
                    errors++;
                    $display("FAIL wrap_%0d_%0d: data=%h, want %h", r, k, bus.rd_data_o, 8'(8'h80 + r * 3 + k));
                end
                step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`else
                step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                checks++;
                if (bus.rd_data_o !== 8'(8'h80 + r * 3 + k) || bus.rd_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_%0d_%0d: data=%h v=%b, want %h 1", r, k, bus.rd_data_o,
                             bus.rd_valid_o, 8'(8'h80 + r * 3 + k));
                end
`endif
            end
            $display("wrap round %0d: cnt=%0d", r, bus.fifo_count_o);
        end
        checks++;
        if (bus.fifo_count_o !== 3'd0 || bus.empty_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_end: cnt=%0d e=%b, want 0 1", bus.fifo_count_o, bus.empty_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_q[$];
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0, 1'b0);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h66};
`ifdef SYNC_FIFO_FWFT_EN
        checks++;
        if (bus.rd_data_o !== 8'hA0) begin
            errors++;
            $display("FAIL full_rw_data: data=%h, want a0", bus.rd_data_o);
        end
`endif
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        $display("full rd+wr 66: cnt=%0d full=%b ovf=%b", bus.fifo_count_o, bus.full_o, bus.overflow_o);
        checks++;
        if (bus.fifo_count_o !== 3'd5 || bus.full_o !== 1'b1 || bus.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL full_rw: cnt=%0d f=%b ovf=%b, want 5 1 0", bus.fifo_count_o, bus.full_o, bus.overflow_o);
        end
`ifndef SYNC_FIFO_FWFT_EN
        checks++;
        if (bus.rd_data_o !== 8'hA0 || bus.rd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL full_rw_data: data=%h v=%b, want a0 1", bus.rd_data_o, bus.rd_valid_o);
        end
`endif
        for (int k = 1; k < 6; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
            checks++;
            if (bus.rd_data_o !== exp_q[k]) begin
                errors++;
                $display("FAIL drain_%0d: data=%h, want %h", k, bus.rd_data_o, exp_q[k]);
            end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`else
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.rd_data_o !== exp_q[k]) begin
                errors++;
                $display("FAIL drain_%0d: data=%h, want %h", k, bus.rd_data_o, exp_q[k]);
            end
`endif
        end
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        $display("empty rd+wr 77: cnt=%0d unf=%b", bus.fifo_count_o, bus.underflow_o);
        checks++;
        if (bus.fifo_count_o !== 3'd1 || bus.underflow_o !== 1'b1) begin
            errors++;
            $display("FAIL empty_rw: cnt=%0d unf=%b, want 1 1", bus.fifo_count_o, bus.underflow_o);
        end
`ifdef SYNC_FIFO_FWFT_EN
        checks++;
        if (bus.rd_data_o !== 8'h77) begin
            errors++;
            $display("FAIL empty_rw_read: data=%h, want 77", bus.rd_data_o);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
`else
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.rd_data_o !== 8'h77 || bus.rd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL empty_rw_read: data=%h v=%b, want 77 1", bus.rd_data_o, bus.rd_valid_o);
        end
`endif
    endtask

    task automatic test_flush();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.fifo_count_o !== 3'd3 || bus.underflow_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: cnt=%0d unf=%b, want 3 1", bus.fifo_count_o, bus.underflow_o);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        $display("flush+wr: cnt=%0d empty=%b unf=%b", bus.fifo_count_o, bus.empty_o, bus.underflow_o);
        checks++;
        if (bus.fifo_count_o !== 3'd0 || bus.empty_o !== 1'b1 ||
            bus.underflow_o !== 1'b1 || bus.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL flush: cnt=%0d e=%b unf=%b ovf=%b, want 0 1 1 0", bus.fifo_count_o,
                     bus.empty_o, bus.underflow_o, bus.overflow_o);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.underflow_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_err_hold: unf=%b, want 1", bus.underflow_o);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_err_clr: unf=%b, want 0", bus.underflow_o);
        end
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        checks++;
        if (bus.rd_data_o !== 8'h99) begin
            errors++;
            $display("FAIL flush_reuse: data=%h, want 99", bus.rd_data_o);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`else
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.rd_data_o !== 8'h99) begin
            errors++;
            $display("FAIL flush_reuse: data=%h, want 99", bus.rd_data_o);
        end
`endif
    endtask

    task automatic test_async_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        bus.wr_en_i = 1'b0;
        checks++;
        if (bus.fifo_count_o !== 3'd2 || bus.underflow_o !== 1'b1 || bus.rd_data_o === 8'h00) begin
            errors++;
            $display("FAIL areset_pre: cnt=%0d unf=%b data=%h, want 2 1 nonzero",
                     bus.fifo_count_o, bus.underflow_o, bus.rd_data_o);
        end
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-cycle: cnt=%0d empty=%b data=%h", bus.fifo_count_o, bus.empty_o, bus.rd_data_o);
        checks++;
        if (bus.fifo_count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.almost_empty_o !== 1'b1 ||
            bus.rd_data_o !== 8'h00 || bus.rd_valid_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL areset: cnt=%0d e=%b ae=%b data=%h v=%b unf=%b, want 0 1 1 00 0 0",
                     bus.fifo_count_o, bus.empty_o, bus.almost_empty_o, bus.rd_data_o,
                     bus.rd_valid_o, bus.underflow_o);
        end
        #1 rst_n = 1'b1;
        step(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.fifo_count_o !== 3'd1) begin
            errors++;
            $display("FAIL areset_post: cnt=%0d, want 1", bus.fifo_count_o);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = 8'h00;
        bus.rd_en_i   = 1'b0;
        bus.flush_i   = 1'b0;
        bus.clr_err_i = 1'b0;
        #2;
        test_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_fill();
        test_read();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and synchronous flush. Supports any depth ≥ 2, including non-power-of-two depths. Serves as the general buffering primitive between pipeline stages of the GPGPU core (instruction buffers, LSU request queues, writeback staging), where producers need early back-pressure warning.

## Interface
Parameters:
- DATA_WIDTH, 64, width of each entry
- FIFO_DEPTH, 4, number of entries; ≥ 2; any integer
- AFULL_THRESH, FIFO_DEPTH-1, almost_full_o asserted when count ≥ this; range 1..FIFO_DEPTH
- AEMPTY_THRESH, 1, almost_empty_o asserted when count ≤ this; range 0..FIFO_DEPTH-1

Ports (CW = $clog2(FIFO_DEPTH+1)):
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush_i  in  1  synchronous clear of pointers and count
- wr_en_i  in  1  write request
- wr_data_i  in  DATA_WIDTH  write data
- rd_en_i  in  1  read request
- rd_data_o  out  DATA_WIDTH  read data
- rd_valid_o  out  1  rd_data_o holds valid data (meaning depends on mode)
- empty_o  out  1  count == 0
- full_o  out  1  count == FIFO_DEPTH
- almost_full_o  out  1  count ≥ AFULL_THRESH
- almost_empty_o  out  1  count ≤ AEMPTY_THRESH
- fifo_count_o  out  CW  current occupancy, registered
- clr_err_i  in  1  clears sticky error flags
- overflow_o  out  1  sticky: write rejected
- underflow_o  out  1  sticky: read rejected

## Operation
- rd_acc = rd_en_i && !empty_o.
- wr_acc = wr_en_i && (!full_o || rd_acc); a write to a full FIFO succeeds when a read is accepted in the same cycle.
- Pointers wr_addr/rd_addr are width $clog2(FIFO_DEPTH). Each advances on its accept and wraps from FIFO_DEPTH-1 to 0; no reliance on power-of-two overflow.
- Count next value: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Count never exceeds FIFO_DEPTH and never underflows.
- Empty, simultaneous rd/wr: the write is accepted, the read is rejected, count becomes 1, and underflow_o is set.
- overflow_o is set on wr_en_i && !wr_acc. underflow_o is set on rd_en_i && !rd_acc.
- Error flags hold until clr_err_i. If set and clear occur in the same cycle, the set wins.
- flush_i takes priority over rd/wr in the same cycle: pointers and count go to 0 and no accepts happen. Error flags and storage are not affected.
- Storage array is not reset; its contents after reset or flush are don't-care.
- almost_full_o, almost_empty_o, empty_o and full_o are compare logic on the registered count, with no combinational path from inputs.

## Timing
- Reset values: fifo_count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, rd_data_o=0, rd_valid_o=0, overflow_o=0, underflow_o=0.
- Write-to-readable latency is 1 cycle: the entry is counted and visible the cycle after wr_acc.
- Standard mode (macro absent):
  - rd_data_o is registered and loaded with mem[rd_addr] on rd_acc.
  - rd_valid_o pulses high for the single cycle after rd_acc.
  - rd_data_o holds its last value otherwise.
- Flags and count update on the edge following the accepting cycle.
- rst_n assertion mid-operation immediately clears all registered outputs and pointers, regardless of clk.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rd_data_o = mem[rd_addr] combinationally when !empty_o, otherwise 0.
  - rd_valid_o = !empty_o.
  - rd_en_i pops the displayed word, so read latency is 0.
  - The rd_data_o register is removed.
- SYNC_FIFO_FWFT_EN undefined: standard registered-read behaviour as under Timing.

## Structure
- Shared package fifo_pkg holds:
  - typedef fifo_err_t, a struct {overflow, underflow}
  - function fifo_ptr_next(ptr, depth) implementing wrap-at-depth
  - localparam helper for count width
- One sub-module, fifo_ptr_wrap (parameter DEPTH; inputs clk, rst_n, clr, inc; output ptr), is instantiated twice, once for wr_addr and once for rd_addr.
- Elaboration-time assertions check FIFO_DEPTH ≥ 2 and that both thresholds are within range.

## Test plan
All scenarios use DATA_WIDTH=8, FIFO_DEPTH=5, AFULL_THRESH=4, AEMPTY_THRESH=1.
- Write 0x11..0x55 with no reads.
  - Count steps 1..5; almost_empty_o deasserts at count 2, almost_full_o asserts at count 4, full_o asserts at count 5.
  - A 6th write sets overflow_o; count stays 5.
- Fill, then read 7 times (standard mode).
  - Data 0x11..0x55 appears in order, each with a 1-cycle rd_valid_o pulse.
  - Reads 6 and 7 set underflow_o; empty_o=1.
- Wrap-around: push 3 and pop 3, repeated 4 times.
  - Data order is preserved across the 4→0 pointer wrap; count ends at 0.
- Full with simultaneous rd_en_i/wr_en_i of 0x66: both are accepted and count stays 5. Empty with simultaneous rd/wr of 0x77: count becomes 1, underflow_o=1, and the next read returns 0x77.
- Count at 3, then flush_i together with wr_en_i: count becomes 0 and empty_o=1. Errors stay as they were until clr_err_i, which clears them the next cycle.
- Assert rst_n low mid-fill at count 2: outputs return to their reset values immediately. Repeat scenario 2 with SYNC_FIFO_FWFT_EN defined: rd_data_o shows 0x11 one cycle after the first write, and rd_valid_o tracks !empty_o.
